// File: rtl/ta_update_sequencer.sv
// Walks every (clause, LA chunk) pair and runs a read / update / write-back cycle on the TA state RAM.
// Four cycles per pair when the RAM handshakes immediately; requests are held until acked, and abort wins over everything.
module ta_update_sequencer #(
  parameter logic [16:0] CLAUSES   = 17'h0000A,
  parameter logic [16:0] LA_CHUNKS = 17'h0000A
) (
  input  logic        clk,
  input  logic        rst_flag,
  input  logic        start,
  input  logic        abort,
  output logic [16:0] clause_idx,
  output logic [16:0] la_chunk_idx,
  output logic        rd_req,
  input  logic        rd_ack,
  input  logic        rd_valid,
  output logic        upd_en,
  output logic        wr_req,
  input  logic        wr_ack,
  output logic        busy,
  output logic        done,
  output logic        aborted
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_REQ, S_RD_WAIT, S_UPDATE, S_WR_REQ, S_DONE
  } state_t;

  localparam logic [16:0] LAST_CLAUSE = CLAUSES - 17'd1;
  localparam logic [16:0] LAST_CHUNK  = LA_CHUNKS - 17'd1;

  state_t state;

  always_ff @(posedge clk or posedge rst_flag) begin
    if (rst_flag) begin
      state        <= S_IDLE;
      clause_idx   <= '0;
      la_chunk_idx <= '0;
      rd_req       <= 1'b0;
      upd_en       <= 1'b0;
      wr_req       <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      aborted      <= 1'b0;
    end else begin
      upd_en  <= 1'b0;
      done    <= 1'b0;
      aborted <= 1'b0;
      // Abort outranks any same-cycle ack; a write acked here still counts as done by the RAM.
      if (state != S_IDLE && abort) begin
        state        <= S_IDLE;
        clause_idx   <= '0;
        la_chunk_idx <= '0;
        rd_req       <= 1'b0;
        wr_req       <= 1'b0;
        busy         <= 1'b0;
        aborted      <= 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              state        <= S_RD_REQ;
              clause_idx   <= '0;
              la_chunk_idx <= '0;
              rd_req       <= 1'b1;
              busy         <= 1'b1;
            end
          end
          S_RD_REQ: begin
            if (rd_ack) begin
              state  <= S_RD_WAIT;
              rd_req <= 1'b0;
            end
          end
          S_RD_WAIT: begin
            if (rd_valid) begin
              state  <= S_UPDATE;
              upd_en <= 1'b1;
            end
          end
          S_UPDATE: begin
            state  <= S_WR_REQ;
            wr_req <= 1'b1;
          end
          S_WR_REQ: begin
            if (wr_ack) begin
              wr_req <= 1'b0;
              if (clause_idx == LAST_CLAUSE && la_chunk_idx == LAST_CHUNK) begin
                state        <= S_DONE;
                done         <= 1'b1;
                clause_idx   <= '0;
                la_chunk_idx <= '0;
              end else begin
                state  <= S_RD_REQ;
                rd_req <= 1'b1;
                if (la_chunk_idx == LAST_CHUNK) begin
                  la_chunk_idx <= '0;
                  clause_idx   <= clause_idx + 17'd1;
                end else begin
                  la_chunk_idx <= la_chunk_idx + 17'd1;
                end
              end
            end
          end
          S_DONE: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state        <= S_IDLE;
            clause_idx   <= '0;
            la_chunk_idx <= '0;
            rd_req       <= 1'b0;
            wr_req       <= 1'b0;
            busy         <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ta_update_sequencer.sv
// Directed bench for ta_update_sequencer: a 2x3 instance and a 1x1 instance, with scoreboard-checked update/done/abort events.
module tb_ta_update_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_flag;
  logic        start, abort, rd_ack, rd_valid, wr_ack;
  logic [16:0] clause_idx, la_chunk_idx;
  logic        rd_req, upd_en, wr_req, busy, done, aborted;

  logic        s1_start, s1_abort, s1_rd_ack, s1_rd_valid, s1_wr_ack;
  logic [16:0] s1_clause_idx, s1_la_chunk_idx;
  logic        s1_rd_req, s1_upd_en, s1_wr_req, s1_busy, s1_done, s1_aborted;

  ta_update_sequencer #(.CLAUSES(17'd2), .LA_CHUNKS(17'd3)) u0 (
    .clk(clk), .rst_flag(rst_flag), .start(start), .abort(abort),
    .clause_idx(clause_idx), .la_chunk_idx(la_chunk_idx),
    .rd_req(rd_req), .rd_ack(rd_ack), .rd_valid(rd_valid), .upd_en(upd_en),
    .wr_req(wr_req), .wr_ack(wr_ack), .busy(busy), .done(done), .aborted(aborted)
  );

  ta_update_sequencer #(.CLAUSES(17'd1), .LA_CHUNKS(17'd1)) u1 (
    .clk(clk), .rst_flag(rst_flag), .start(s1_start), .abort(s1_abort),
    .clause_idx(s1_clause_idx), .la_chunk_idx(s1_la_chunk_idx),
    .rd_req(s1_rd_req), .rd_ack(s1_rd_ack), .rd_valid(s1_rd_valid), .upd_en(s1_upd_en),
    .wr_req(s1_wr_req), .wr_ack(s1_wr_ack), .busy(s1_busy), .done(s1_done), .aborted(s1_aborted)
  );

  typedef struct {
    int kind;  // 0 = upd_en, 1 = done, 2 = aborted
    int c;
    int l;
  } ev_t;

  ev_t q0[$];
  ev_t q1[$];
  int  total = 0;
  int  bad = 0;
  int  upd_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic exp0(input int k, input int c, input int l);
    ev_t e;
    e = '{k, c, l};
    q0.push_back(e);
  endtask

  task automatic exp1(input int k, input int c, input int l);
    ev_t e;
    e = '{k, c, l};
    q1.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin : mon0
    int  k;
    ev_t e;
    if (!rst_flag) begin
      check("excl0", {rd_req & wr_req, upd_en & (rd_req | wr_req)}, 0);
      if (upd_en || done || aborted) begin
        k = upd_en ? 0 : (done ? 1 : 2);
        if (upd_en) upd_cnt++;
        if (q0.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb0_unexpected: event kind %0d seen, none expected", k);
        end else begin
          e = q0.pop_front();
          check("sb0_kind", k, e.kind);
          check("sb0_clause", clause_idx, e.c);
          check("sb0_chunk", la_chunk_idx, e.l);
        end
      end
    end
  end

  always @(negedge clk) begin : mon1
    int  k;
    ev_t e;
    if (!rst_flag) begin
      check("excl1", {s1_rd_req & s1_wr_req, s1_upd_en & (s1_rd_req | s1_wr_req)}, 0);
      if (s1_upd_en || s1_done || s1_aborted) begin
        k = s1_upd_en ? 0 : (s1_done ? 1 : 2);
        if (q1.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb1_unexpected: event kind %0d seen, none expected", k);
        end else begin
          e = q1.pop_front();
          check("sb1_kind", k, e.kind);
          check("sb1_clause", s1_clause_idx, e.c);
          check("sb1_chunk", s1_la_chunk_idx, e.l);
        end
      end
    end
  end

  // One pair on u0, entered in RD_REQ; ra/rv/wa are stall cycles, st pulses start mid-pair.
  task automatic pair(input int c, input int l, input int ra, input int rv, input int wa, input bit st);
    logic [33:0] exp_idx;
    exp_idx = {c[16:0], l[16:0]};
    exp0(0, c, l);
    check("rd_req", rd_req, 1);
    check("pair_idx", {clause_idx, la_chunk_idx}, exp_idx);
    if (st) start = 1'b1;
    rd_valid = (ra > 0);
    repeat (ra) begin
      tick();
      start = 1'b0;
      check("rd_hold", {rd_req, wr_req, clause_idx, la_chunk_idx}, {2'b10, exp_idx});
    end
    rd_ack = 1'b1;
    tick();
    rd_ack = 1'b0;
    rd_valid = 1'b0;
    start = 1'b0;
    repeat (rv) begin
      check("rd_wait", {rd_req, upd_en, wr_req}, 0);
      tick();
    end
    rd_valid = 1'b1;
    tick();
    rd_valid = 1'b0;
    check("upd", {upd_en, rd_req, wr_req}, 3'b100);
    tick();
    check("wr_req", {rd_req, upd_en, wr_req}, 3'b001);
    repeat (wa) begin
      tick();
      check("wr_hold", {wr_req, clause_idx, la_chunk_idx}, {1'b1, exp_idx});
    end
    wr_ack = 1'b1;
    tick();
    wr_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int u;
    rst_flag = 1'b1;
    {start, abort, rd_ack, rd_valid, wr_ack} = '0;
    {s1_start, s1_abort, s1_rd_ack, s1_rd_valid, s1_wr_ack} = '0;
    repeat (2) tick();
    check("rst_outs0", {clause_idx, la_chunk_idx, rd_req, upd_en, wr_req, busy, done, aborted}, 0);
    check("rst_outs1", {s1_clause_idx, s1_la_chunk_idx, s1_rd_req, s1_upd_en, s1_wr_req, s1_busy, s1_done, s1_aborted}, 0);
    rst_flag = 1'b0;
    tick();
    check("idle_busy", busy, 0);

    // Zero-wait sweep; start and abort together in IDLE must start.
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("start_busy", {busy, aborted}, 2'b10);
    for (int c = 0; c < 2; c++)
      for (int l = 0; l < 3; l++)
        pair(c, l, 0, 0, 0, 1'b0);
    exp0(1, 0, 0);
    check("done_c25", {done, busy}, 2'b11);
    tick();
    check("busy_c26", {done, busy}, 2'b00);

    // Stalled pair (0,1), start pulse ignored during (0,2).
    u = upd_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 2; c++)
      for (int l = 0; l < 3; l++)
        pair(c, l, (c == 0 && l == 1) ? 5 : 0, (c == 0 && l == 1) ? 3 : 0,
             (c == 0 && l == 1) ? 4 : 0, (c == 0 && l == 2));
    exp0(1, 0, 0);
    check("done2", done, 1);
    tick();
    check("busy2_low", busy, 0);
    check("upd_count", upd_cnt - u, 6);

    // Abort in RD_WAIT of pair (1,0), then restart at (0,0).
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int l = 0; l < 3; l++) pair(0, l, 0, 0, 0, 1'b0);
    check("p10_idx", {rd_req, clause_idx, la_chunk_idx}, {1'b1, 17'd1, 17'd0});
    rd_ack = 1'b1;
    tick();
    rd_ack = 1'b0;
    check("rd_wait_state", {rd_req, upd_en, wr_req, busy}, 4'b0001);
    abort = 1'b1;
    exp0(2, 0, 0);
    tick();
    abort = 1'b0;
    check("abort_idle", {busy, rd_req, wr_req, upd_en, done, aborted}, 6'b000001);
    check("abort_idx", {clause_idx, la_chunk_idx}, 0);
    tick();
    check("abort_after", {aborted, done, busy}, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("restart", {clause_idx, la_chunk_idx, rd_req}, 1);

    // Asynchronous reset while in WR_REQ.
    rd_ack = 1'b1;
    tick();
    rd_ack = 1'b0;
    rd_valid = 1'b1;
    exp0(0, 0, 0);
    tick();
    rd_valid = 1'b0;
    tick();
    check("wr_req_pre", wr_req, 1);
    #2 rst_flag = 1'b1;
    #1;
    check("async_rst", {clause_idx, la_chunk_idx, rd_req, upd_en, wr_req, busy, done, aborted}, 0);
    @(negedge clk);
    #1 rst_flag = 1'b0;
    tick();
    check("post_rst", {busy, done, aborted, rd_req, wr_req}, 0);

    // 1x1 instance: one pair then done.
    s1_start = 1'b1;
    exp1(0, 0, 0);
    tick();
    s1_start = 1'b0;
    check("s1_rd_req", {s1_rd_req, s1_busy}, 2'b11);
    s1_rd_ack = 1'b1;
    tick();
    s1_rd_ack = 1'b0;
    s1_rd_valid = 1'b1;
    tick();
    s1_rd_valid = 1'b0;
    check("s1_upd", s1_upd_en, 1);
    tick();
    check("s1_wr_req", {s1_rd_req, s1_wr_req}, 2'b01);
    exp1(1, 0, 0);
    s1_wr_ack = 1'b1;
    tick();
    s1_wr_ack = 1'b0;
    check("s1_done", {s1_done, s1_busy}, 2'b11);
    tick();
    check("s1_idle", {s1_done, s1_busy}, 0);

    // 1x1: abort coincident with the final wr_ack.
    s1_start = 1'b1;
    exp1(0, 0, 0);
    tick();
    s1_start = 1'b0;
    s1_rd_ack = 1'b1;
    tick();
    s1_rd_ack = 1'b0;
    s1_rd_valid = 1'b1;
    tick();
    s1_rd_valid = 1'b0;
    tick();
    s1_wr_ack = 1'b1;
    s1_abort = 1'b1;
    exp1(2, 0, 0);
    tick();
    s1_wr_ack = 1'b0;
    s1_abort = 1'b0;
    check("s1_abort", {s1_aborted, s1_done, s1_busy, s1_wr_req}, 4'b1000);
    tick();
    check("s1_abort_after", {s1_aborted, s1_done, s1_busy}, 0);

    tick();
    check("sb_drain", q0.size() + q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ta_update_sequencer.md
Name: ta_update_sequencer

Overview:
- Sequences the read-modify-write update of Tsetlin Automata state memory.
- Walks every (clause, LA chunk) pair in clause-major order and issues a read request per pair.
- Pulses the TA update datapath when read data returns, then issues the write-back.
- Sits between the training controller (start/abort/done) and the TA state RAM port.

Parameters:
CLAUSES, 17'h0000A, number of clauses to walk (>=1)
LA_CHUNKS, 17'h0000A, LA chunks per clause (>=1)

Ports:
clk  input  1  system clock, rising edge
rst_flag  input  1  asynchronous active-high reset
start  input  1  begin a full sweep; sampled in IDLE only
abort  input  1  terminate sweep; effective in any non-IDLE state
clause_idx  output  17  current clause address
la_chunk_idx  output  17  current LA chunk address
rd_req  output  1  read request; held until rd_ack
rd_ack  input  1  RAM accepted read
rd_valid  input  1  read data available (arbitrary latency after rd_ack)
upd_en  output  1  one-cycle pulse: update datapath consumes read data
wr_req  output  1  write-back request; held until wr_ack
wr_ack  input  1  RAM accepted write
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse after the final write is acknowledged
aborted  output  1  one-cycle pulse when abort is taken

Behaviour:
- Clocking and reset:
  - All outputs registered (Moore).
  - rst_flag forces IDLE immediately, mid-sweep included; all outputs and indices go to 0.
  - No pending request survives reset.
- States: IDLE, RD_REQ, RD_WAIT, UPDATE, WR_REQ, DONE.
- IDLE:
  - busy=0.
  - start=1 -> RD_REQ with clause_idx=0, la_chunk_idx=0.
- RD_REQ:
  - rd_req=1; indices stable.
  - rd_ack=1 -> RD_WAIT; else stay.
- RD_WAIT:
  - rd_valid=1 -> UPDATE; else stay.
  - rd_valid seen in RD_REQ is ignored.
- UPDATE: upd_en=1 for exactly one cycle -> WR_REQ.
- WR_REQ:
  - wr_req=1; indices unchanged.
  - On wr_ack=1:
    - last pair (clause_idx==CLAUSES-1 and la_chunk_idx==LA_CHUNKS-1) -> DONE.
    - la_chunk_idx==LA_CHUNKS-1 -> la_chunk_idx=0, clause_idx+1, RD_REQ.
    - else la_chunk_idx+1, RD_REQ.
- DONE:
  - done=1 for one cycle; indices reset to 0 -> IDLE.
  - busy is low on the cycle after done.
- Per-pair latency with zero-wait handshakes (ack in first request cycle, rd_valid the cycle after RD_WAIT entry): 4 cycles (RD_REQ, RD_WAIT, UPDATE, WR_REQ).
  - Full sweep = 4*CLAUSES*LA_CHUNKS + 1 (DONE) cycles after the start-sampling edge.
- Abort:
  - abort=1 in any non-IDLE state, DONE included, has priority over every other transition, including a same-cycle ack.
  - Next state IDLE; indices 0; aborted=1 for one cycle; done not asserted.
  - A write acked in the abort cycle is considered performed.
- start while busy is ignored. start and abort together in IDLE: start is taken, abort ignored.
- Index arithmetic is 17-bit unsigned. Indices never exceed CLAUSES-1 / LA_CHUNKS-1. No wrap beyond sweep end.
- CLAUSES=1, LA_CHUNKS=1: single pair, then DONE.
- rd_req and wr_req are never high together. upd_en is never high with either request.

Test Plan:
- CLAUSES=2, LA_CHUNKS=3, acks immediate, rd_valid 1 cycle later -> visit order (0,0),(0,1),(0,2),(1,0),(1,1),(1,2); 6 upd_en pulses; done at cycle 25 after start; busy low cycle 26.
- Hold rd_ack low 5 cycles, rd_valid 3 cycles after ack, wr_ack low 4 cycles on pair (0,1) -> rd_req/wr_req held steady, indices unchanged during stall, single upd_en per pair.
- Assert abort in RD_WAIT of pair (1,0) -> next cycle IDLE, aborted pulse, indices 0, no done. A following start restarts at (0,0).
- Assert start during pair (0,2) -> ignored, sweep completes normally with exactly 6 upd_en.
- Assert rst_flag asynchronously mid WR_REQ -> outputs 0 immediately, state IDLE, no done/aborted pulse.
- CLAUSES=1, LA_CHUNKS=1 -> one read, one upd_en, one write, done. Abort coincident with wr_ack on the final pair -> aborted pulse, no done.
